// File: rtl/fpu_norm_pkg.sv
// Shared types and width helpers for the FPU normaliser path.
package fpu_norm_pkg;

    typedef enum logic {
        LZ_ZEROS = 1'b0,
        LZ_ONES  = 1'b1
    } lz_mode_e;

    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/lz_normalizer_if.sv
// Upstream/downstream valid-ready bundle for lz_normalizer.
interface lz_normalizer_if #(
    parameter int WIDTH = 32
);
    localparam int CW = fpu_norm_pkg::count_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ones;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_all;

    modport slave (
        input  in_valid, in_data, in_ones, out_ready,
        output in_ready, out_valid, out_data, out_count, out_all
    );

    modport master (
        output in_valid, in_data, in_ones, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_all
    );

endinterface

// File: rtl/lz_normalizer_count.sv
// Combinational leading-digit counter: binary tree of (any-set, count) pairs.
module lz_count
    import fpu_norm_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int CW    = count_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  lz_mode_e         i_mode,
    output logic [CW-1:0]    o_count
);

    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;

    logic [WIDTH-1:0] w_norm;
    logic [P-1:0]     w_pad;

    assign w_norm = (i_mode == LZ_ONES) ? ~i_data : i_data;

    // Padding with ones stops the count at WIDTH for non-power-of-two widths.
    if (P > WIDTH) begin : g_pad
        assign w_pad = {w_norm, {(P-WIDTH){1'b1}}};
    end else begin : g_nopad
        assign w_pad = w_norm;
    end

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        logic [(P>>j)-1:0]   v;
        logic [j*(P>>j)-1:0] c;
        for (genvar n = 0; n < (P>>j); n++) begin : g_node
            if (j == 1) begin : g_leaf
                assign v[n] = w_pad[2*n+1] | w_pad[2*n];
                assign c[n] = ~w_pad[2*n+1];
            end else begin : g_join
                assign v[n] = g_lvl[j-1].v[2*n+1] | g_lvl[j-1].v[2*n];
                assign c[j*n +: j] = g_lvl[j-1].v[2*n+1]
                    ? {1'b0, g_lvl[j-1].c[(j-1)*(2*n+1) +: (j-1)]}
                    : {1'b1, g_lvl[j-1].c[(j-1)*(2*n)   +: (j-1)]};
            end
        end
    end

    assign o_count = g_lvl[L].v[0] ? {1'b0, g_lvl[L].c} : CW'(WIDTH);

endmodule

// File: rtl/lz_normalizer.sv
// Two-stage leading-digit count (S1) and normalising shift (S2) with valid/ready flow control.
module lz_normalizer
    import fpu_norm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    lz_normalizer_if.slave  bus
);

    localparam int CW = count_width(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    lz_mode_e         r_s1_mode;
    logic [CW-1:0]    r_s1_count;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic [CW-1:0]    r_s2_count;
    logic             r_s2_all;

    logic             w_s1_load;
    logic             w_s2_load;
    lz_mode_e         w_in_mode;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_shift;

    assign w_s2_load   = ~r_s2_valid | bus.out_ready;
    assign w_s1_load   = ~r_s1_valid | w_s2_load;
    assign bus.in_ready = w_s1_load;
    assign w_in_mode   = lz_mode_e'(bus.in_ones);

    lz_count #(.WIDTH(WIDTH)) u_count (
        .i_data  (bus.in_data),
        .i_mode  (w_in_mode),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= LZ_ZEROS;
            r_s1_count <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data  <= bus.in_data;
                r_s1_mode  <= w_in_mode;
                r_s1_count <= w_count;
            end
        end
    end

    // Barrel shifter; shifts of WIDTH or more leave only fill bits.
    assign w_fill = {WIDTH{r_s1_mode == LZ_ONES}};

    always_comb begin
        w_shift = r_s1_data;
        for (int k = 0; k < CW; k++) begin
            if (r_s1_count[k]) begin
                w_shift = (w_shift << (1 << k)) | (w_fill & ~(ONES << (1 << k)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_count <= '0;
            r_s2_all   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= w_shift;
                r_s2_count <= r_s1_count;
                r_s2_all   <= (r_s1_count == CW'(WIDTH));
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_count = r_s2_count;
    assign bus.out_all   = r_s2_all;

endmodule

// File: tb/tb_lz_normalizer.sv
// Randomised and directed checks of lz_normalizer at WIDTH=32 and WIDTH=24 against a bit-walking model.
module tb_lz_normalizer;
    import fpu_norm_pkg::*;

    localparam int RDY_ALWAYS = 0;
    localparam int RDY_RAND   = 1;
    localparam int RDY_STALL  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lz_normalizer_if #(.WIDTH(32)) if32 ();
    lz_normalizer_if #(.WIDTH(24)) if24 ();

    lz_normalizer #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    lz_normalizer #(.WIDTH(24)) u_dut24 (.clk(clk), .rst_n(rst_n), .bus(if24.slave));

    typedef struct {
        logic [31:0] d;
        bit          ones;
        logic [31:0] ed;
        int          ec;
        bit          ea;
    } item_t;

    item_t in_q[$];
    item_t exp_q[$];
    int    acc_q[$];
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk from the MSB counting digits equal to the mode bit, then shift and fill.
    task automatic ref_norm(input int w, input logic [31:0] d, input bit ones,
                            output logic [31:0] nd, output int cnt, output bit all);
        logic [63:0] mask;
        logic [63:0] x;
        mask = (64'd1 << w) - 64'd1;
        cnt = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i] == ones) cnt++;
            else break;
        end
        x = ({32'd0, d} << cnt);
        if (ones) x = x | ((64'd1 << cnt) - 64'd1);
        nd  = 32'(x & mask);
        all = (cnt == w);
    endtask

    task automatic add(input logic [31:0] d, input bit ones,
                       input logic [31:0] ed, input int ec, input bit ea);
        item_t it;
        it.d = d; it.ones = ones; it.ed = ed; it.ec = ec; it.ea = ea;
        in_q.push_back(it);
    endtask

    task automatic add_rand(input int w, input int n);
        item_t it;
        logic [31:0] mask;
        int sh;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int i = 0; i < n; i++) begin
            sh = $urandom_range(0, w);
            it.d = (sh >= 32) ? 32'd0 : (($urandom & mask) >> sh);
            it.ones = $urandom_range(0, 1) == 1;
            if (it.ones) it.d = ~it.d & mask;
            ref_norm(w, it.d, it.ones, it.ed, it.ec, it.ea);
            in_q.push_back(it);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input logic [31:0] d, input bit ones, input bit r);
        if (sel) begin
            if24.in_valid = v; if24.in_data = d[23:0]; if24.in_ones = ones; if24.out_ready = r;
        end else begin
            if32.in_valid = v; if32.in_data = d; if32.in_ones = ones; if32.out_ready = r;
        end
    endtask

    task automatic sample(input bit sel, output bit ov, output logic [31:0] od,
                          output int oc, output bit oa, output bit ir);
        if (sel) begin
            ov = if24.out_valid; od = {8'd0, if24.out_data}; oc = int'(if24.out_count);
            oa = if24.out_all;   ir = if24.in_ready;
        end else begin
            ov = if32.out_valid; od = if32.out_data; oc = int'(if32.out_count);
            oa = if32.out_all;   ir = if32.in_ready;
        end
    endtask

    task automatic run(input bit sel, input int rdy_mode, input int stall_n,
                       input bit rand_valid, input bit chk_lat);
        int it, n, budget, acc_stall;
        bit v, r, ov, oa, ir, done;
        logic [31:0] od;
        int oc;
        it = 0; acc_stall = 0; done = 0;
        n = in_q.size();
        budget = 20 * n + 50;
        while (!done) begin
            @(negedge clk);
            v = (in_q.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
            case (rdy_mode)
                RDY_ALWAYS: r = 1'b1;
                RDY_RAND:   r = $urandom_range(0, 1) == 1;
                default:    r = (it >= stall_n);
            endcase
            if (v) drive(sel, 1'b1, in_q[0].d, in_q[0].ones, r);
            else   drive(sel, 1'b0, $urandom, $urandom_range(0, 1) == 1, r);
            #1;
            sample(sel, ov, od, oc, oa, ir);
            if (ov) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", ov, 0);
                end else begin
                    chk("data",  od, exp_q[0].ed);
                    chk("count", oc, exp_q[0].ec);
                    chk("all",   oa, exp_q[0].ea);
                    if (r) begin
                        if (chk_lat) chk("latency", it - acc_q[0], 2);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (v && ir) begin
                exp_q.push_back(in_q.pop_front());
                acc_q.push_back(it);
                if (rdy_mode == RDY_STALL && it < stall_n) acc_stall++;
            end
            it++;
            if (in_q.size() == 0 && exp_q.size() == 0) begin
                done = 1;
            end else if (it > budget) begin
                chk("drain_timeout", in_q.size() + exp_q.size(), 0);
                in_q.delete(); exp_q.delete(); acc_q.delete();
                done = 1;
            end
        end
        drive(sel, 1'b0, 32'd0, 1'b0, 1'b1);
        if (rdy_mode == RDY_STALL) chk("stall_accepts", acc_stall, 2);
        if (chk_lat) chk("drain_cycles", it, n + 2);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        bit ov, oa, ir;
        logic [31:0] od;
        int oc;

        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h0000_8000, 1'b0, 1'b1);

        // Reset held with a word presented upstream.
        repeat (3) begin
            @(negedge clk);
            sample(1'b0, ov, od, oc, oa, ir);
            chk("rst_valid", ov, 0);
            chk("rst_data",  od, 0);
            chk("rst_count", oc, 0);
            chk("rst_all",   oa, 0);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            sample(1'b0, ov, od, oc, oa, ir);
            chk("post_rst_ready", ir, 1);
            chk("post_rst_valid", ov, 0);
        end

        add(32'h0000_0000, 1'b0, 32'h0000_0000, 32, 1'b1);
        add(32'h0000_8000, 1'b0, 32'h8000_0000, 16, 1'b0);
        add(32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0);
        add(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 0,  1'b0);
        add(32'hFF00_0000, 1'b1, 32'h0000_00FF, 8,  1'b0);
        add(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32, 1'b1);
        add(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 0,  1'b0);
        add(32'h8000_0000, 1'b0, 32'h8000_0000, 0,  1'b0);
        run(1'b0, RDY_ALWAYS, 0, 1'b0, 1'b1);

        add_rand(32, 8);
        run(1'b0, RDY_STALL, 5, 1'b0, 1'b0);

        add_rand(32, 16);
        run(1'b0, RDY_ALWAYS, 0, 1'b0, 1'b1);

        add_rand(32, 1000);
        run(1'b0, RDY_RAND, 0, 1'b1, 1'b0);

        add(32'h0000_0001, 1'b0, 32'h0080_0000, 23, 1'b0);
        add(32'h0000_0000, 1'b0, 32'h0000_0000, 24, 1'b1);
        add(32'h00FF_FFFF, 1'b1, 32'h00FF_FFFF, 24, 1'b1);
        add(32'h0000_F000, 1'b1, 32'h0000_F000, 0,  1'b0);
        run(1'b1, RDY_ALWAYS, 0, 1'b0, 1'b1);

        add_rand(24, 200);
        run(1'b1, RDY_RAND, 0, 1'b1, 1'b0);

        // Fill both stages, then pulse reset between clock edges.
        repeat (3) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        end
        @(negedge clk);
        sample(1'b1, ov, od, oc, oa, ir);
        chk("pre_rst_valid", ov, 1);
        chk("pre_rst_ready", ir, 0);
        #2;
        rst_n = 1'b0;
        #1;
        sample(1'b1, ov, od, oc, oa, ir);
        chk("mid_rst_valid", ov, 0);
        chk("mid_rst_count", oc, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sample(1'b1, ov, od, oc, oa, ir);
            chk("restart_valid", ov, 0);
            chk("restart_ready", ir, 1);
        end

        add_rand(24, 12);
        run(1'b1, RDY_ALWAYS, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
